// File: rtl/sdram_demo_pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// The master side is the sequencer itself; the slave side is the PLL/system wrapper.
interface sdram_demo_pll_reset_sequencer_if;
    logic       pll_locked;
    logic       sw_relock;
    logic       pll_rst;
    logic       sys_reset_n;
    logic [2:0] state;
    logic [7:0] retry_count;
    logic [7:0] lock_loss_count;
    logic       error;

    modport master (
        input  pll_locked,
        input  sw_relock,
        output pll_rst,
        output sys_reset_n,
        output state,
        output retry_count,
        output lock_loss_count,
        output error
    );

    modport slave (
        output pll_locked,
        output sw_relock,
        input  pll_rst,
        input  sys_reset_n,
        input  state,
        input  retry_count,
        input  lock_loss_count,
        input  error
    );
endinterface

// File: rtl/sdram_demo_pll_reset_sequencer.sv
// Brings the system PLL from power-up to qualified lock, releases the system reset,
// then supervises lock; runs on the free-running board reference clock.
module sdram_demo_pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int RELEASE_DELAY_CYCLES = 64,
    parameter int MAX_RETRIES          = 3
) (
    input logic clk,
    input logic reset_n,
    sdram_demo_pll_reset_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_RESET_PLL   = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_STABLE      = 3'd2,
        ST_RELEASE_DLY = 3'd3,
        ST_RUN         = 3'd4,
        ST_ERROR       = 3'd5
    } state_t;

    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_B   = (LOCK_STABLE_CYCLES > RELEASE_DELAY_CYCLES) ? LOCK_STABLE_CYCLES : RELEASE_DELAY_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // One extra value of headroom: STABLE compares against the full cycle count.
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_DONE  = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [7:0]       RETRY_LAST   = 8'(MAX_RETRIES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt;
    logic             sync_meta;
    logic             locked_s;
    logic             pll_rst_q;
    logic             sys_reset_n_q;
    logic [7:0]       retry_q;
    logic [7:0]       lock_loss_q;
    logic             error_q;

    // pll_rst follows the previous state, so it rises one edge after entering RESET_PLL
    // and stays high for exactly the pulse length; sys_reset_n moves with the transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_RESET_PLL;
            cnt           <= '0;
            sync_meta     <= 1'b0;
            locked_s      <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            retry_q       <= 8'd0;
            lock_loss_q   <= 8'd0;
            error_q       <= 1'b0;
        end else begin
            sync_meta <= bus.pll_locked;
            locked_s  <= sync_meta;
            pll_rst_q <= (state_q == ST_RESET_PLL) || (state_q == ST_ERROR);

            if ((state_q == ST_RUN) && !locked_s) begin
                state_q       <= ST_RESET_PLL;
                cnt           <= '0;
                sys_reset_n_q <= 1'b0;
                if (lock_loss_q != 8'hFF) begin
                    lock_loss_q <= lock_loss_q + 8'd1;
                end
            end else if (bus.sw_relock) begin
                state_q       <= ST_RESET_PLL;
                cnt           <= '0;
                sys_reset_n_q <= 1'b0;
                retry_q       <= 8'd0;
                error_q       <= 1'b0;
            end else begin
                case (state_q)
                    ST_RESET_PLL: begin
                        if (cnt == RST_LAST) begin
                            state_q <= ST_WAIT_LOCK;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (locked_s) begin
                            state_q <= ST_STABLE;
                            cnt     <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            retry_q <= retry_q + 8'd1;
                            cnt     <= '0;
                            if (retry_q == RETRY_LAST) begin
                                state_q <= ST_ERROR;
                                error_q <= 1'b1;
                            end else begin
                                state_q <= ST_RESET_PLL;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_STABLE: begin
                        if (!locked_s) begin
                            state_q <= ST_WAIT_LOCK;
                            cnt     <= '0;
                        end else if (cnt == STABLE_DONE) begin
                            state_q <= ST_RELEASE_DLY;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RELEASE_DLY: begin
                        if (!locked_s) begin
                            state_q <= ST_RESET_PLL;
                            cnt     <= '0;
                        end else if (cnt == RELEASE_LAST) begin
                            state_q       <= ST_RUN;
                            cnt           <= '0;
                            sys_reset_n_q <= 1'b1;
                            retry_q       <= 8'd0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RUN, ST_ERROR: begin
                        cnt <= '0;
                    end
                    default: begin
                        state_q       <= ST_RESET_PLL;
                        cnt           <= '0;
                        sys_reset_n_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pll_rst         = pll_rst_q;
    assign bus.sys_reset_n     = sys_reset_n_q;
    assign bus.state           = state_q;
    assign bus.retry_count     = retry_q;
    assign bus.lock_loss_count = lock_loss_q;
    assign bus.error           = error_q;

endmodule

// File: tb/tb_sdram_demo_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer with small cycle parameters
// (pulse 4, timeout 32, stable 8, release 4, two retries).
module tb_sdram_demo_pll_reset_sequencer;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    sdram_demo_pll_reset_sequencer_if bus_if ();

    sdram_demo_pll_reset_sequencer #(
        .RST_PULSE_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES  (32),
        .LOCK_STABLE_CYCLES   (8),
        .RELEASE_DELAY_CYCLES (4),
        .MAX_RETRIES          (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic locked, input logic relock);
        bus_if.pll_locked = locked;
        bus_if.sw_relock  = relock;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic waitState(input string tag, input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while ((bus_if.state !== target) && (n < budget)) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(bus_if.state), 32'(target));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset held for five edges, then released.
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick(5);
        checkOutput("rst_state", 32'(bus_if.state), 32'd0);
        checkOutput("rst_pll_rst", 32'(bus_if.pll_rst), 32'd1);
        checkOutput("rst_sys_reset_n", 32'(bus_if.sys_reset_n), 32'd0);
        checkOutput("rst_retry", 32'(bus_if.retry_count), 32'd0);
        checkOutput("rst_lock_loss", 32'(bus_if.lock_loss_count), 32'd0);
        checkOutput("rst_error", 32'(bus_if.error), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("pulse_high", 32'(bus_if.pll_rst), 32'd1);
        end
        checkOutput("pulse_state_wait", 32'(bus_if.state), 32'd1);
        tick(1);
        checkOutput("pulse_low", 32'(bus_if.pll_rst), 32'd0);
        checkOutput("pulse_sys_reset_n", 32'(bus_if.sys_reset_n), 32'd0);

        // Lock appears ten cycles into WAIT_LOCK and stays.
        tick(9);
        applyStimulus(1'b1, 1'b0);
        tick(3);
        checkOutput("bring_stable", 32'(bus_if.state), 32'd2);
        tick(12);
        checkOutput("bring_release", 32'(bus_if.state), 32'd3);
        checkOutput("bring_sys_low", 32'(bus_if.sys_reset_n), 32'd0);
        tick(1);
        checkOutput("bring_sys_high", 32'(bus_if.sys_reset_n), 32'd1);
        checkOutput("bring_run", 32'(bus_if.state), 32'd4);

        // Short lock pulse during STABLE must restart qualification.
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick(2);
        reset_n = 1'b1;
        waitState("glitch_wait_entry", 3'd1, 10);
        applyStimulus(1'b1, 1'b0);
        tick(3);
        checkOutput("glitch_stable", 32'(bus_if.state), 32'd2);
        applyStimulus(1'b0, 1'b0);
        tick(5);
        checkOutput("glitch_back_wait", 32'(bus_if.state), 32'd1);
        applyStimulus(1'b1, 1'b0);
        tick(3);
        checkOutput("glitch_stable_again", 32'(bus_if.state), 32'd2);
        tick(12);
        checkOutput("glitch_sys_low", 32'(bus_if.sys_reset_n), 32'd0);
        tick(1);
        checkOutput("glitch_sys_high", 32'(bus_if.sys_reset_n), 32'd1);
        checkOutput("glitch_run", 32'(bus_if.state), 32'd4);
        checkOutput("glitch_retry", 32'(bus_if.retry_count), 32'd0);

        // Lock never comes: two timeouts lead to ERROR.
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        checkOutput("to_wait1", 32'(bus_if.state), 32'd1);
        tick(31);
        checkOutput("to_before1", 32'(bus_if.retry_count), 32'd0);
        tick(1);
        checkOutput("to_state_rst", 32'(bus_if.state), 32'd0);
        checkOutput("to_retry1", 32'(bus_if.retry_count), 32'd1);
        checkOutput("to_pll_rst_lag", 32'(bus_if.pll_rst), 32'd0);
        tick(1);
        checkOutput("to_pll_rst_rise", 32'(bus_if.pll_rst), 32'd1);
        tick(3);
        checkOutput("to_pll_rst_last", 32'(bus_if.pll_rst), 32'd1);
        tick(1);
        checkOutput("to_pll_rst_fall", 32'(bus_if.pll_rst), 32'd0);
        tick(30);
        checkOutput("to_wait2", 32'(bus_if.state), 32'd1);
        tick(1);
        checkOutput("to_error_state", 32'(bus_if.state), 32'd5);
        checkOutput("to_error_flag", 32'(bus_if.error), 32'd1);
        checkOutput("to_retry2", 32'(bus_if.retry_count), 32'd2);
        tick(1);
        checkOutput("to_error_pll_rst", 32'(bus_if.pll_rst), 32'd1);
        tick(10);
        checkOutput("to_error_hold", 32'(bus_if.state), 32'd5);
        checkOutput("to_error_sys", 32'(bus_if.sys_reset_n), 32'd0);

        // Software relock out of ERROR with lock already present.
        applyStimulus(1'b1, 1'b0);
        tick(3);
        applyStimulus(1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("sw_state", 32'(bus_if.state), 32'd0);
        checkOutput("sw_error_clr", 32'(bus_if.error), 32'd0);
        checkOutput("sw_retry_clr", 32'(bus_if.retry_count), 32'd0);
        tick(4);
        checkOutput("sw_wait", 32'(bus_if.state), 32'd1);
        tick(1);
        checkOutput("sw_stable", 32'(bus_if.state), 32'd2);
        tick(12);
        checkOutput("sw_sys_low", 32'(bus_if.sys_reset_n), 32'd0);
        tick(1);
        checkOutput("sw_sys_high", 32'(bus_if.sys_reset_n), 32'd1);
        checkOutput("sw_lock_loss", 32'(bus_if.lock_loss_count), 32'd0);

        // One-cycle lock drop in RUN.
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("loss_sys_e1", 32'(bus_if.sys_reset_n), 32'd1);
        tick(1);
        checkOutput("loss_sys_e2", 32'(bus_if.sys_reset_n), 32'd1);
        tick(1);
        checkOutput("loss_sys_e3", 32'(bus_if.sys_reset_n), 32'd0);
        checkOutput("loss_state", 32'(bus_if.state), 32'd0);
        checkOutput("loss_count", 32'(bus_if.lock_loss_count), 32'd1);
        checkOutput("loss_pll_rst_lag", 32'(bus_if.pll_rst), 32'd0);
        tick(1);
        checkOutput("loss_pll_rst_rise", 32'(bus_if.pll_rst), 32'd1);
        tick(3);
        checkOutput("loss_pll_rst_last", 32'(bus_if.pll_rst), 32'd1);
        tick(1);
        checkOutput("loss_pll_rst_fall", 32'(bus_if.pll_rst), 32'd0);
        checkOutput("loss_stable", 32'(bus_if.state), 32'd2);
        tick(12);
        checkOutput("loss_sys_still_low", 32'(bus_if.sys_reset_n), 32'd0);
        tick(1);
        checkOutput("loss_relock_sys", 32'(bus_if.sys_reset_n), 32'd1);
        checkOutput("loss_relock_run", 32'(bus_if.state), 32'd4);

        // Lock loss and software relock in the same cycle count once.
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("both_state", 32'(bus_if.state), 32'd0);
        checkOutput("both_count", 32'(bus_if.lock_loss_count), 32'd2);
        checkOutput("both_sys", 32'(bus_if.sys_reset_n), 32'd0);
        waitState("both_relock_run", 3'd4, 40);
        checkOutput("both_relock_sys", 32'(bus_if.sys_reset_n), 32'd1);

        // Software relock in RUN leaves the lock-loss count alone.
        applyStimulus(1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("swrun_state", 32'(bus_if.state), 32'd0);
        checkOutput("swrun_sys", 32'(bus_if.sys_reset_n), 32'd0);
        checkOutput("swrun_count", 32'(bus_if.lock_loss_count), 32'd2);
        waitState("swrun_relock_run", 3'd4, 40);
        checkOutput("swrun_count_after", 32'(bus_if.lock_loss_count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
